// File: rtl/reg_file.sv
// reg_file: RV32 architectural register file with a post-reset sequential clear,
// x0 hardwiring and write-to-read bypass on both read ports.
module reg_file #(
    parameter int unsigned NREG = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     op_write_top,
    input  logic [31:0]              write_pc_reg_addr,
    input  logic [XLEN-1:0]          write_pc_reg_value,
    input  logic [31:0]              load_pc_reg_addr1,
    input  logic [31:0]              load_pc_reg_addr2,
    output logic [XLEN-1:0]          load_pc_reg_value1,
    output logic [XLEN-1:0]          load_pc_reg_value2,
    output logic                     rf_ready,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [XLEN-1:0]          dbg_data
);

    localparam int unsigned IDX_W = $clog2(NREG);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREG - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]     mem_q [NREG];

    logic [IDX_W-1:0]    widx_c, ridx1_c, ridx2_c;
    logic                wr_fire_c;
    logic                mem_we_c;
    logic [IDX_W-1:0]    mem_waddr_c;
    logic [XLEN-1:0]     mem_wdata_c;
    logic [XLEN-1:0]     rd1_c, rd2_c, dbg_c;

    // Only the low index bits address the file; the rest are don't-care.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{write_pc_reg_addr[31:IDX_W],
                                 load_pc_reg_addr1[31:IDX_W],
                                 load_pc_reg_addr2[31:IDX_W]};

    assign widx_c    = write_pc_reg_addr[IDX_W-1:0];
    assign ridx1_c   = load_pc_reg_addr1[IDX_W-1:0];
    assign ridx2_c   = load_pc_reg_addr2[IDX_W-1:0];
    assign wr_fire_c = op_write_top && (widx_c != IDX_ZERO);

    // State register: synchronous reset restarts the clear sequence at x1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= IDX_FIRST;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: walk clr_idx from x1 to the last entry, then enter RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == IDX_LAST) begin
                state_d = ST_RUN;
            end else begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs: single array write port plus read muxes with x0 and bypass.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = IDX_ZERO;
        mem_wdata_c = '0;
        rd1_c       = '0;
        rd2_c       = '0;
        dbg_c       = '0;
        if (state_q == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_idx_q;
        end else begin
            if (wr_fire_c) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = widx_c;
                mem_wdata_c = write_pc_reg_value;
            end
            if (ridx1_c != IDX_ZERO) begin
                rd1_c = (wr_fire_c && (widx_c == ridx1_c)) ? write_pc_reg_value
                                                          : mem_q[ridx1_c];
            end
            if (ridx2_c != IDX_ZERO) begin
                rd2_c = (wr_fire_c && (widx_c == ridx2_c)) ? write_pc_reg_value
                                                          : mem_q[ridx2_c];
            end
            if (dbg_addr != IDX_ZERO) begin
                dbg_c = mem_q[dbg_addr];
            end
        end
    end

    // Storage array: no reset so it maps onto a single-write-port RAM; reset drops writes.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign load_pc_reg_value1 = rd1_c;
    assign load_pc_reg_value2 = rd2_c;
    assign dbg_data           = dbg_c;
    assign rf_ready           = (state_q == ST_RUN);

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the 5-stage RV32 pipeline. It sits directly beside the pipeline top: it consumes `load_pc_reg_addr1/2`, `write_pc_reg_addr`, `write_pc_reg_value` and `op_write_top`, and returns `load_pc_reg_value1/2` to the decode stage. After reset it runs a sequential clear engine that zeroes x1..x31 one entry per cycle, so the array maps onto single-write-port RAM. In normal operation it provides x0 hardwiring and write-to-read bypass, so WB and ID can share a cycle without a hazard.

## Interface
- `NREG`, 32, number of architectural registers; index width is log2(NREG) = 5.
- `XLEN`, 32, register data width.

Ports:
- `clk` input 1: system clock. Everything is sampled on the rising edge.
- `reset_n` input 1: reset, synchronous and active-low. It is sampled only on the rising edge of `clk`.
- `op_write_top` input 1: write enable from WB.
- `write_pc_reg_addr` input 32: write index. Only bits [4:0] are used; [31:5] are ignored.
- `write_pc_reg_value` input 32: write data.
- `load_pc_reg_addr1` input 32: read port 1 index. Only bits [4:0] are used.
- `load_pc_reg_addr2` input 32: read port 2 index. Only bits [4:0] are used.
- `load_pc_reg_value1` output 32: read port 1 data (combinational).
- `load_pc_reg_value2` output 32: read port 2 data (combinational).
- `rf_ready` output 1: high when the clear sequence is complete and the file is usable.
- `dbg_addr` input 5: debug/testbench read index.
- `dbg_data` output 32: raw array contents at `dbg_addr`, with no bypass (combinational).

## Operation
- The FSM has two states, CLEAR and RUN. A 5-bit clear index `clr_idx` is associated with CLEAR.
- **Reset.** On any edge with `reset_n`=0: state becomes CLEAR, `clr_idx` becomes 1, `rf_ready` becomes 0. This applies from any state, including mid-CLEAR, where the sequence restarts at index 1.
- **CLEAR.** On each edge with `reset_n`=1:
  - mem[clr_idx] is set to 0 and `clr_idx` increments.
  - On the edge where `clr_idx`=31 is written, the next state is RUN.
  - All `op_write_top` requests are dropped.
  - Both read ports and `dbg_data` return 0.
- **RUN, writes.** If `op_write_top`=1 and the write index ≠ 0, mem[widx] is set to `write_pc_reg_value`. Writes to x0 are silently discarded.
- **RUN, reads** (each port independently):
  - Index 0 returns 0.
  - Otherwise, if `op_write_top`=1 and the write index equals the read index, the port returns `write_pc_reg_value` (bypass).
  - Otherwise the port returns mem[index].
- `rf_ready` = (state == RUN), driven from a registered state bit.
- x0 has no storage, or its storage is never read; the array is never written at index 0.
- No arithmetic is performed beyond `clr_idx` incrementing from 1 to 31; the index never wraps.

## Timing
- Reset values: state = CLEAR, `clr_idx` = 1, `rf_ready` = 0. `load_pc_reg_value1`, `load_pc_reg_value2` and `dbg_data` are 0 while in CLEAR. Array contents are undefined until cleared.
- Clear latency: `rf_ready` rises exactly 31 rising edges after the first edge at which `reset_n` is sampled high.
- Write latency: 1 edge. Data written at edge N is visible through the array (and `dbg_data`) after edge N. It is visible through bypass during the write cycle itself.
- Read latency: 0 cycles (combinational from addresses, `op_write_top` and write data).
- Simultaneous events:
  - Both ports reading the same index is legal; both ports bypass.
  - A write and a reset on the same edge: reset wins and the write is dropped.
  - A write on the edge that moves CLEAR to RUN is dropped.
  - The first accepted write occurs on the edge after `rf_ready` reads 1.
- `reset_n` is never used asynchronously. A low pulse between edges that is not sampled has no effect.

## Test plan
- **Reset and clear.** Hold `reset_n`=0 for 3 edges, then release. Required: `rf_ready`=0 for 30 edges and =1 after the 31st. `dbg_data`=0 for `dbg_addr` 1..31 after clear. Both read ports return 0 during clear even while `op_write_top`=1 to x5 with 0xDEADBEEF, and x5 remains 0 afterward.
- **Basic write/read.** In RUN, write x7 = 0x12345678. Next cycle, `load_pc_reg_addr1`=7 returns 0x12345678. `write_pc_reg_addr`=0x27 (upper bits set) writes x7 as well.
- **x0.** Write x0 = 0xFFFFFFFF. Both ports return 0 at index 0 during and after the write, and `dbg_data`[0]=0.
- **Bypass.** x3 holds 0x1. In one cycle write x3 = 0xA5A5A5A5 with both read addresses = 3. Both ports show 0xA5A5A5A5 in that cycle. With `op_write_top`=0 and the same addresses, both ports show the old value 0x1.
- **Reset mid-operation.** Assert `reset_n`=0 for 1 edge at `clr_idx`=15, then release. `rf_ready` rises 31 edges later. In a second run, reset in RUN with x9 = 0x55: after re-clear, x9 = 0.
- **Reset/write collision.** `reset_n`=0 and a write of x4 = 0x77 on the same edge. After clear, x4 = 0.
